// File: rtl/mem_responder.sv
// Memory-side responder: 256x16 RAM plus switch/LED registers, answering each
// CPU transaction with a one-cycle mem_ready pulse after WAIT_STATES busy cycles.
module mem_responder #(
  parameter int         WAIT_STATES = 0,
  parameter logic [8:0] SW_ADDR     = 9'h140,
  parameter logic [8:0] LED_ADDR    = 9'h100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic        mem_err,
  input  logic [7:0]  sw,
  output logic [7:0]  led
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;
  localparam logic [3:0] CNT_INIT  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        is_write_q, is_write_d;
  logic [15:0] read_data_q, read_data_d;
  logic        mem_ready_q, mem_ready_d;
  logic        mem_err_q, mem_err_d;
  logic [7:0]  led_q, led_d;

  logic [15:0] ram [0:255];

  logic        commit;
  logic        bad_cmd;
  logic        hit_ram, hit_led, hit_sw;
  logic [15:0] rd_word;
  logic        ram_we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    commit     = 1'b0;
    bad_cmd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_cmd == CMD_READ || mem_cmd == CMD_WRITE) begin
          addr_d     = mem_addr;
          wdata_d    = write_data;
          is_write_d = (mem_cmd == CMD_WRITE);
          if (WAIT_STATES == 0) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end else if (mem_cmd == CMD_RSVD) begin
          bad_cmd = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The *_d copies equal the live inputs on a zero-wait accept and the latched
  // values otherwise, so the commit always uses the transaction's own operands.
  always_comb begin
    hit_ram = ~addr_d[8];
    hit_led = ~hit_ram && (addr_d == LED_ADDR);
    hit_sw  = ~hit_ram && ~hit_led && (addr_d == SW_ADDR);
    rd_word = 16'h0000;
    if (hit_ram) begin
      rd_word = ram[addr_d[7:0]];
    end else if (hit_led) begin
      rd_word = {8'h00, led_q};
    end else if (hit_sw) begin
      rd_word = {8'h00, sw};
    end
  end

  always_comb begin
    read_data_d = read_data_q;
    led_d       = led_q;
    if (commit && !is_write_d) begin
      read_data_d = rd_word;
    end
    if (commit && is_write_d && hit_led) begin
      led_d = wdata_d[7:0];
    end
    mem_ready_d = commit;
    mem_err_d   = (commit && !(hit_ram || hit_led || hit_sw)) || bad_cmd;
  end

  // Reset gates the RAM port directly: while reset is held the FSM sits in
  // IDLE, where a zero-wait accept would otherwise look like a commit.
  assign ram_we = reset && commit && is_write_d && hit_ram;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[addr_d[7:0]] <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 9'd0;
      wdata_q     <= 16'h0000;
      is_write_q  <= 1'b0;
      read_data_q <= 16'h0000;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      led_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      read_data_q <= read_data_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      led_q       <= led_d;
    end
  end

  assign read_data = read_data_q;
  assign mem_ready = mem_ready_q;
  assign mem_err   = mem_err_q;
  assign led       = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with zero wait states and one
// with three, driven step by step with hand-computed expectations.
module tb_mem_responder;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [1:0]  cmd0 = NONE, cmd3 = NONE;
  logic [8:0]  addr0 = '0, addr3 = '0;
  logic [15:0] wd0 = '0, wd3 = '0;
  logic [7:0]  sw0 = '0, sw3 = '0;
  logic [15:0] rd0, rd3;
  logic        rdy0, rdy3, err0, err3;
  logic [7:0]  led0, led3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(0), .SW_ADDR(9'h140), .LED_ADDR(9'h100)) u_dut0 (
    .clk(clk), .reset(reset), .mem_cmd(cmd0), .mem_addr(addr0), .write_data(wd0),
    .read_data(rd0), .mem_ready(rdy0), .mem_err(err0), .sw(sw0), .led(led0)
  );

  mem_responder #(.WAIT_STATES(3), .SW_ADDR(9'h140), .LED_ADDR(9'h100)) u_dut3 (
    .clk(clk), .reset(reset), .mem_cmd(cmd3), .mem_addr(addr3), .write_data(wd3),
    .read_data(rd3), .mem_ready(rdy3), .mem_err(err3), .sw(sw3), .led(led3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_rd0", rd0, 16'h0000);
    chk("rst_rdy0", {15'd0, rdy0}, 16'd0);
    chk("rst_err0", {15'd0, err0}, 16'd0);
    chk("rst_led0", {8'd0, led0}, 16'h0000);
    tick(); tick();
    reset = 1'b1;

    // Zero wait states: write then read back
    cmd0 = WRITE; addr0 = 9'h005; wd0 = 16'hBEEF;
    tick();
    chk("w0_rdy", {15'd0, rdy0}, 16'd1);
    chk("w0_err", {15'd0, err0}, 16'd0);
    chk("w0_rd_unchanged", rd0, 16'h0000);
    cmd0 = NONE;
    tick();
    chk("w0_rdy_low", {15'd0, rdy0}, 16'd0);
    cmd0 = READ; addr0 = 9'h005; wd0 = 16'h0000;
    tick();
    chk("r0_rdy", {15'd0, rdy0}, 16'd1);
    chk("r0_data", rd0, 16'hBEEF);
    cmd0 = NONE;
    tick();
    chk("r0_rdy_low", {15'd0, rdy0}, 16'd0);
    chk("r0_hold", rd0, 16'hBEEF);
    tick();
    chk("r0_hold2", rd0, 16'hBEEF);

    // MMIO
    cmd0 = WRITE; addr0 = 9'h100; wd0 = 16'hA5C3;
    tick();
    chk("led_rdy", {15'd0, rdy0}, 16'd1);
    chk("led_val", {8'd0, led0}, 16'h00C3);
    chk("led_wr_rd_hold", rd0, 16'hBEEF);
    cmd0 = NONE;
    tick();
    sw0 = 8'h7E; cmd0 = READ; addr0 = 9'h140;
    tick();
    chk("sw_rdy", {15'd0, rdy0}, 16'd1);
    chk("sw_read", rd0, 16'h007E);
    cmd0 = NONE;
    tick();
    cmd0 = READ; addr0 = 9'h100;
    tick();
    chk("led_read", rd0, 16'h00C3);
    cmd0 = NONE;
    tick();
    cmd0 = WRITE; addr0 = 9'h140; wd0 = 16'hFFFF;
    tick();
    chk("sw_wr_rdy", {15'd0, rdy0}, 16'd1);
    chk("sw_wr_noerr", {15'd0, err0}, 16'd0);
    chk("sw_wr_led", {8'd0, led0}, 16'h00C3);
    cmd0 = NONE;
    tick();

    // Errors
    cmd0 = READ; addr0 = 9'h1FF;
    tick();
    chk("unm_rdy", {15'd0, rdy0}, 16'd1);
    chk("unm_err", {15'd0, err0}, 16'd1);
    chk("unm_data", rd0, 16'h0000);
    cmd0 = NONE;
    tick();
    chk("unm_err_clr", {15'd0, err0}, 16'd0);
    cmd0 = RSVD;
    tick();
    chk("rsvd_err", {15'd0, err0}, 16'd1);
    chk("rsvd_nordy", {15'd0, rdy0}, 16'd0);
    cmd0 = NONE;
    tick();
    chk("rsvd_err_clr", {15'd0, err0}, 16'd0);
    chk("rsvd_nordy2", {15'd0, rdy0}, 16'd0);
    cmd0 = READ; addr0 = 9'h005;
    tick();
    chk("rsvd_idle_rdy", {15'd0, rdy0}, 16'd1);
    chk("rsvd_idle_data", rd0, 16'hBEEF);
    cmd0 = NONE;
    tick();

    // Held read command: pulses every second cycle
    cmd0 = READ; addr0 = 9'h005;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("held_rdy_%0d", i), {15'd0, rdy0}, (i % 2 == 0) ? 16'd1 : 16'd0);
    end
    cmd0 = NONE;
    tick();
    chk("held_end", {15'd0, rdy0}, 16'd0);

    // Three wait states: seed RAM, LED and location 0x010
    cmd3 = WRITE; addr3 = 9'h000; wd3 = 16'hAAAA;
    tick(); cmd3 = NONE; tick(); tick(); tick(); tick();
    cmd3 = WRITE; addr3 = 9'h100; wd3 = 16'h00FF;
    tick(); cmd3 = NONE; tick(); tick(); tick(); tick();
    chk("w3_led", {8'd0, led3}, 16'h00FF);
    cmd3 = WRITE; addr3 = 9'h010; wd3 = 16'h0001;
    tick(); cmd3 = NONE; tick(); tick(); tick(); tick();
    cmd3 = WRITE; addr3 = 9'h0FF; wd3 = 16'h1234;
    tick();
    cmd3 = NONE;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w3_busy_%0d", i), {15'd0, rdy3}, 16'd0);
      tick();
    end
    chk("w3_rdy", {15'd0, rdy3}, 16'd1);
    tick();

    // Read with address disturbed during BUSY
    cmd3 = READ; addr3 = 9'h0FF;
    tick();
    cmd3 = NONE; addr3 = 9'h000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r3_busy_%0d", i), {15'd0, rdy3}, 16'd0);
      tick();
    end
    chk("r3_rdy", {15'd0, rdy3}, 16'd1);
    chk("r3_data", rd3, 16'h1234);
    tick();
    chk("r3_rdy_low", {15'd0, rdy3}, 16'd0);

    // Reset in the middle of a write
    cmd3 = WRITE; addr3 = 9'h010; wd3 = 16'h5555;
    tick();
    cmd3 = NONE;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_rd", rd3, 16'h0000);
    chk("arst_led", {8'd0, led3}, 16'h0000);
    chk("arst_rdy", {15'd0, rdy3}, 16'd0);
    chk("arst_err", {15'd0, err3}, 16'd0);
    tick(); tick(); tick(); tick();
    chk("arst_hold_rdy", {15'd0, rdy3}, 16'd0);
    reset = 1'b1;
    cmd3 = READ; addr3 = 9'h010;
    tick();
    cmd3 = NONE;
    tick(); tick(); tick();
    chk("post_rst_rdy", {15'd0, rdy3}, 16'd1);
    chk("post_rst_data", rd3, 16'h0001);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
